// File: rtl/chip8_pkg.sv
// Shared constants and types for the CHIP-8 display path: screen geometry,
// colour type and the default 640x480@60 VGA timing.
package chip8_pkg;

    localparam int CHIP8_W = 64;
    localparam int CHIP8_H = 32;
    localparam int FB_BITS = CHIP8_W * CHIP8_H;

    typedef logic [11:0] rgb12_t;

    localparam int DEF_PIX_DIV  = 4;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_SCALE    = 10;
    localparam int DEF_V_OFFSET = 80;

    localparam rgb12_t DEF_FG_COLOR     = 12'hFFF;
    localparam rgb12_t DEF_BG_COLOR     = 12'h000;
    localparam rgb12_t DEF_BORDER_COLOR = 12'h222;

    // Framebuffer bit index y*64+x without a multiplier.
    function automatic logic [10:0] cell_index(input logic [4:0] cy, input logic [5:0] cx);
        return {cy, cx};
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-clock divider plus horizontal/vertical scan counters producing the raw
// (unregistered) sync and active flags for the current scan position.
module vga_timing
    import chip8_pkg::*;
#(
    parameter int PIX_DIV  = DEF_PIX_DIV,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic       clk,
    input  logic       reset,
    output logic       pix_tick_o,
    output logic [9:0] h_o,
    output logic [9:0] v_o,
    output logic       hsync_raw_o,
    output logic       vsync_raw_o,
    output logic       active_raw_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       h_q, h_d, v_q, v_d;
    logic             pix_tick;

    assign pix_tick = (div_q == DIV_LAST);

    always_comb begin
        div_d = pix_tick ? '0 : div_q + 1'b1;
        h_d   = h_q;
        v_d   = v_q;
        if (pix_tick) begin
            if (h_q == 10'(H_TOTAL - 1)) begin
                h_d = '0;
                v_d = (v_q == 10'(V_TOTAL - 1)) ? '0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q <= '0;
            h_q   <= '0;
            v_q   <= '0;
        end else begin
            div_q <= div_d;
            h_q   <= h_d;
            v_q   <= v_d;
        end
    end

    assign pix_tick_o   = pix_tick;
    assign h_o          = h_q;
    assign v_o          = v_q;
    assign hsync_raw_o  = !((h_q >= 10'(H_ACTIVE + H_FP)) && (h_q < 10'(H_ACTIVE + H_FP + H_SYNC)));
    assign vsync_raw_o  = !((v_q >= 10'(V_ACTIVE + V_FP)) && (v_q < 10'(V_ACTIVE + V_FP + V_SYNC)));
    assign active_raw_o = (h_q < 10'(H_ACTIVE)) && (v_q < 10'(V_ACTIVE));

endmodule

// File: rtl/chip8_vga_scanner.sv
// Scans a per-frame shadow copy of the 64x32 CHIP-8 framebuffer out as VGA,
// each CHIP-8 pixel drawn as a SCALE x SCALE block in a vertically centred window.
module chip8_vga_scanner
    import chip8_pkg::*;
#(
    parameter int     PIX_DIV      = DEF_PIX_DIV,
    parameter int     H_ACTIVE     = DEF_H_ACTIVE,
    parameter int     H_FP         = DEF_H_FP,
    parameter int     H_SYNC       = DEF_H_SYNC,
    parameter int     H_BP         = DEF_H_BP,
    parameter int     V_ACTIVE     = DEF_V_ACTIVE,
    parameter int     V_FP         = DEF_V_FP,
    parameter int     V_SYNC       = DEF_V_SYNC,
    parameter int     V_BP         = DEF_V_BP,
    parameter int     SCALE        = DEF_SCALE,
    parameter int     V_OFFSET     = DEF_V_OFFSET,
    parameter rgb12_t FG_COLOR     = DEF_FG_COLOR,
    parameter rgb12_t BG_COLOR     = DEF_BG_COLOR,
    parameter rgb12_t BORDER_COLOR = DEF_BORDER_COLOR
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [FB_BITS-1:0] display,
    output logic               vga_hsync,
    output logic               vga_vsync,
    output logic [3:0]         vga_r,
    output logic [3:0]         vga_g,
    output logic [3:0]         vga_b,
    output logic               frame_start,
    output logic               video_active
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int WIN_END = V_OFFSET + CHIP8_H * SCALE;
    localparam int V_PRE   = (V_OFFSET == 0) ? V_TOTAL - 1 : V_OFFSET - 1;
    localparam int SW      = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam logic [SW-1:0] S_LAST = SW'(SCALE - 1);

    logic       pix_tick, hs_raw, vs_raw, act_raw;
    logic [9:0] h, v;

    vga_timing #(
        .PIX_DIV (PIX_DIV),
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk         (clk),
        .reset       (reset),
        .pix_tick_o  (pix_tick),
        .h_o         (h),
        .v_o         (v),
        .hsync_raw_o (hs_raw),
        .vsync_raw_o (vs_raw),
        .active_raw_o(act_raw)
    );

    logic               line_end, frame_end, in_window, pixel_bit;
    logic [FB_BITS-1:0] shadow_q;
    logic [5:0]         cx_q, cx_d;
    logic [4:0]         cy_q, cy_d;
    logic [SW-1:0]      sx_q, sx_d, sy_q, sy_d;
    rgb12_t             rgb_q, rgb_d;
    logic               hsync_q, vsync_q, active_q, frame_start_q;

    assign line_end  = pix_tick && (h == 10'(H_TOTAL - 1));
    assign frame_end = line_end && (v == 10'(V_TOTAL - 1));
    assign in_window = (v >= 10'(V_OFFSET)) && (v < 10'(WIN_END));

    // Cell counters track h/v so the bit index needs no divide: sx/sy count
    // screen pixels within a cell, cx/cy step once per SCALE of them.
    always_comb begin
        cx_d = cx_q;
        sx_d = sx_q;
        cy_d = cy_q;
        sy_d = sy_q;
        if (line_end) begin
            cx_d = '0;
            sx_d = '0;
            if (v == 10'(V_PRE)) begin
                cy_d = '0;
                sy_d = '0;
            end else if (in_window) begin
                if (sy_q == S_LAST) begin
                    sy_d = '0;
                    cy_d = cy_q + 5'd1;
                end else begin
                    sy_d = sy_q + 1'b1;
                end
            end
        end else if (pix_tick && (h < 10'(H_ACTIVE))) begin
            if (sx_q == S_LAST) begin
                sx_d = '0;
                cx_d = cx_q + 6'd1;
            end else begin
                sx_d = sx_q + 1'b1;
            end
        end
    end

    assign pixel_bit = shadow_q[cell_index(cy_q, cx_q)];

    always_comb begin
        rgb_d = '0;
        if (act_raw) begin
            if (!in_window)     rgb_d = BORDER_COLOR;
            else if (pixel_bit) rgb_d = FG_COLOR;
            else                rgb_d = BG_COLOR;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cx_q     <= '0;
            sx_q     <= '0;
            cy_q     <= '0;
            sy_q     <= '0;
            shadow_q <= '0;
        end else begin
            cx_q <= cx_d;
            sx_q <= sx_d;
            cy_q <= cy_d;
            sy_q <= sy_d;
            if (frame_end) shadow_q <= display;
        end
    end

    // All video outputs share one register stage so they stay aligned.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb_q         <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            active_q      <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= frame_end;
            if (pix_tick) begin
                rgb_q    <= rgb_d;
                hsync_q  <= hs_raw;
                vsync_q  <= vs_raw;
                active_q <= act_raw;
            end
        end
    end

    assign vga_r        = rgb_q[11:8];
    assign vga_g        = rgb_q[7:4];
    assign vga_b        = rgb_q[3:0];
    assign vga_hsync    = hsync_q;
    assign vga_vsync    = vsync_q;
    assign video_active = active_q;
    assign frame_start  = frame_start_q;

endmodule

// File: tb/tb_chip8_vga_scanner.sv
// Randomized bench: two scanners with shrunken timing (PIX_DIV 1 and 4) are
// compared every clock against a geometric model of the scan and the shadow.
module tb_chip8_vga_scanner;

    // DUT A: PIX_DIV=1, SCALE=2
    localparam int A_PD = 1, A_HA = 128, A_HFP = 4, A_HS = 8, A_HBP = 4;
    localparam int A_VA = 80, A_VFP = 2, A_VS = 2, A_VBP = 3, A_SC = 2, A_VO = 8;
    localparam int A_FT = (A_HA + A_HFP + A_HS + A_HBP) * (A_VA + A_VFP + A_VS + A_VBP);
    // DUT B: PIX_DIV=4, SCALE=1
    localparam int B_PD = 4, B_HA = 64, B_HFP = 2, B_HS = 4, B_HBP = 2;
    localparam int B_VA = 40, B_VFP = 1, B_VS = 2, B_VBP = 1, B_SC = 1, B_VO = 4;
    localparam int B_FT = (B_HA + B_HFP + B_HS + B_HBP) * (B_VA + B_VFP + B_VS + B_VBP);

    logic          clk = 1'b0;
    logic          reset;
    logic [2047:0] display;

    logic       hsA, vsA, fsA, vaA, hsB, vsB, fsB, vaB;
    logic [3:0] rA, gA, bA, rB, gB, bB;

    int            vectorCount = 0;
    int            missCount   = 0;
    int            nA = 0, nB = 0;
    logic [2047:0] snapA = '0, snapB = '0;

    always #5 clk = ~clk;

    chip8_vga_scanner #(
        .PIX_DIV(A_PD), .H_ACTIVE(A_HA), .H_FP(A_HFP), .H_SYNC(A_HS), .H_BP(A_HBP),
        .V_ACTIVE(A_VA), .V_FP(A_VFP), .V_SYNC(A_VS), .V_BP(A_VBP),
        .SCALE(A_SC), .V_OFFSET(A_VO)
    ) dutA (
        .clk(clk), .reset(reset), .display(display),
        .vga_hsync(hsA), .vga_vsync(vsA), .vga_r(rA), .vga_g(gA), .vga_b(bA),
        .frame_start(fsA), .video_active(vaA)
    );

    chip8_vga_scanner #(
        .PIX_DIV(B_PD), .H_ACTIVE(B_HA), .H_FP(B_HFP), .H_SYNC(B_HS), .H_BP(B_HBP),
        .V_ACTIVE(B_VA), .V_FP(B_VFP), .V_SYNC(B_VS), .V_BP(B_VBP),
        .SCALE(B_SC), .V_OFFSET(B_VO)
    ) dutB (
        .clk(clk), .reset(reset), .display(display),
        .vga_hsync(hsB), .vga_vsync(vsB), .vga_r(rB), .vga_g(gB), .vga_b(bB),
        .frame_start(fsB), .video_active(vaB)
    );

    // Expected {hsync, vsync, active, frame_start, rgb} after n clocks since reset release.
    function automatic logic [15:0] modelOut(input int pd, input int ha, input int hfp,
            input int hsw, input int hbp, input int va, input int vfp, input int vsw,
            input int vbp, input int scale, input int voff, input int n,
            input logic [2047:0] snap);
        int         ht, vt, p, h, v;
        logic       hs, vs, act, fs;
        logic [11:0] rgb;
        ht = ha + hfp + hsw + hbp;
        vt = va + vfp + vsw + vbp;
        if (n < pd) return {1'b1, 1'b1, 1'b0, 1'b0, 12'h000};
        p   = n / pd - 1;
        h   = p % ht;
        v   = (p / ht) % vt;
        hs  = !(h >= ha + hfp && h < ha + hfp + hsw);
        vs  = !(v >= va + vfp && v < va + vfp + vsw);
        act = (h < ha) && (v < va);
        fs  = (n % pd == 0) && (p % (ht * vt) == ht * vt - 1);
        if (!act)                                rgb = 12'h000;
        else if (v < voff || v >= voff + 32 * scale) rgb = 12'h222;
        else if (snap[((v - voff) / scale) * 64 + h / scale]) rgb = 12'hFFF;
        else                                      rgb = 12'h000;
        return {hs, vs, act, fs, rgb};
    endfunction

    function automatic logic isLoad(input int n, input int pd, input int ft);
        return (n % pd == 0) && ((n / pd - 1) % ft == ft - 1);
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s at %0t: got %h, want %h (hs,vs,act,fs,rgb)",
                     tag, $time, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int kind);
        logic [2047:0] pat;
        pat = '0;
        case (kind)
            0: for (int i = 0; i < 64; i++) pat[i*32 +: 32] = $urandom;
            1: pat[$urandom_range(0, 2047)] = 1'b1;
            2: pat = '1;
            default: for (int i = 0; i < 64; i++) pat[i*32 +: 32] = $urandom & $urandom & $urandom;
        endcase
        display = pat;
    endtask

    // Model state advances on the same edges as the DUTs; display is stable here.
    always @(posedge clk) begin
        if (reset) begin
            nA = 0; nB = 0;
            snapA = '0; snapB = '0;
        end else begin
            nA++; nB++;
            if (isLoad(nA, A_PD, A_FT)) snapA = display;
            if (isLoad(nB, B_PD, B_FT)) snapB = display;
        end
    end

    always @(negedge clk) begin
        checkOutput("dutA", {hsA, vsA, vaA, fsA, rA, gA, bA},
                    modelOut(A_PD, A_HA, A_HFP, A_HS, A_HBP, A_VA, A_VFP, A_VS, A_VBP,
                             A_SC, A_VO, reset ? 0 : nA, snapA));
        checkOutput("dutB", {hsB, vsB, vaB, fsB, rB, gB, bB},
                    modelOut(B_PD, B_HA, B_HFP, B_HS, B_HBP, B_VA, B_VFP, B_VS, B_VBP,
                             B_SC, B_VO, reset ? 0 : nB, snapB));
    end

    task automatic waitClocks(input int c);
        repeat (c) @(posedge clk);
        #2;
    endtask

    initial begin
        reset   = 1'b1;
        display = '0;
        waitClocks(3);
        reset = 1'b0;

        // Top-left pixel set mid frame 0, then bottom-right mid frame 1.
        waitClocks(6000);
        display = '0;
        display[0] = 1'b1;
        waitClocks(10000);
        display = '0;
        display[2047] = 1'b1;

        for (int i = 0; i < 8; i++) begin
            waitClocks($urandom_range(800, 3000));
            applyStimulus(i % 4);
        end

        // Mid-frame reset; the first frame afterwards must show an empty window.
        waitClocks($urandom_range(2000, 5000));
        reset = 1'b1;
        waitClocks(20);
        reset = 1'b0;
        waitClocks(3000);
        applyStimulus(0);
        waitClocks(13000);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/chip8_vga_scanner.md
Name: chip8_vga_scanner

Overview:
Downstream display stage for chip8_cpu. Consumes the CPU's 2048-bit 64x32 framebuffer and scans it out as a 640x480@60 VGA signal. Each CHIP-8 pixel is drawn as a 10x10 block in a 640x320 window, vertically centred with a border band above and below. A per-frame shadow copy of the framebuffer prevents tearing while the CPU draws.

Parameters:
PIX_DIV, 4, system clocks per VGA pixel (4 → 25 MHz from 100 MHz); 1 allowed
H_ACTIVE/H_FP/H_SYNC/H_BP, 640/16/96/48, horizontal timing in pixels (H_TOTAL=800)
V_ACTIVE/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical timing in lines (V_TOTAL=525)
SCALE, 10, screen pixels per CHIP-8 pixel, both axes
V_OFFSET, 80, first active line of the 320-line game window
FG_COLOR, 12'hFFF, {r,g,b} for a set pixel
BG_COLOR, 12'h000, {r,g,b} for a clear pixel
BORDER_COLOR, 12'h222, {r,g,b} for active lines outside the window

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
display  in  2048  framebuffer from chip8_cpu; bit index = y*64 + x, x 0..63, y 0..31
vga_hsync  out  1  horizontal sync, active low
vga_vsync  out  1  vertical sync, active low
vga_r  out  4  red
vga_g  out  4  green
vga_b  out  4  blue
frame_start  out  1  one-clk pulse when the shadow buffer is reloaded
video_active  out  1  high while the output pixel is in the 640x480 active area

Behaviour:
- Single clock domain: clk, asynchronous active-high reset.
- Reset: vga_hsync=1, vga_vsync=1, rgb=0, frame_start=0, video_active=0. Counters and shadow buffer cleared to 0; pixel divider cleared to 0.
- Pixel tick: divider counts 0..PIX_DIV-1 and asserts pix_tick on PIX_DIV-1. With PIX_DIV=1, pix_tick is high every clk. All counters advance only on pix_tick.
- Horizontal counter h: 0..799, wraps to 0. On wrap, vertical counter v advances 0..524 and wraps to 0.
- Sync timing:
  - hsync_raw low for h in [656,751].
  - vsync_raw low for v in [490,491].
  - active_raw = (h<640) && (v<480).
- Window: v in [V_OFFSET, V_OFFSET+319].
- Cell addressing uses no dividers:
  - cx 0..63 with sub-counter sx 0..SCALE-1, advancing per active pixel and cleared at h=0.
  - cy 0..31 with sub-counter sy, advancing per line inside the window and cleared at v=V_OFFSET.
- Pixel bit = shadow[cy*64+cx].
- Colour select:
  - blank (not active_raw) → 0
  - active outside window → BORDER_COLOR
  - inside window → FG_COLOR if bit=1, else BG_COLOR
- Output pipeline: rgb, hsync, vsync and video_active are all registered on pix_tick together, so they stay mutually aligned with a fixed 1-pixel latency relative to h/v. Outputs hold between ticks.
- Shadow load: on the pix_tick where h=799 and v=524, shadow <= display and frame_start pulses for exactly one clk.
  - Changes to display at any other time are invisible until the next load.
  - Every frame shows one coherent snapshot.
- Reset mid-frame: all state returns to reset values immediately. Scanning restarts at h=0, v=0 with an all-clear shadow until the first end-of-frame load.
- Widths: h and v are 10 bits. Cell index cy*64+cx is 11 bits, formed by concatenation {cy[4:0],cx[5:0]}.

Decomposition:
- Package chip8_pkg:
  - Screen constants CHIP8_W=64, CHIP8_H=32, FB_BITS=2048.
  - 12-bit colour typedef.
  - VGA timing defaults.
- Sub-module vga_timing: divider, h/v counters, raw sync and active flags, pix_tick.
- Top: shadow buffer, cell counters, colour mux and output registers.

Test Plan:
- Sync period: PIX_DIV=1, reset released →
  - vga_hsync period 800 clk, low 96 clk, first falling edge at clk 657 after reset release (1-pixel latency).
  - vga_vsync low for 2 lines, every 525 lines.
- Top-left pixel: display bit 0 set, loaded at frame end → rgb=FFF for output h 0..9 on lines 80..89; rgb=000 elsewhere in the window; 222 on lines 0..79 and 400..479.
- Bottom-right pixel: bit 2047 set → rgb=FFF only for h 630..639 on lines 390..399.
- Tearing: set bit 0 mid-frame at v=200 → no FFF output until after frame_start; the following frame shows it.
- PIX_DIV=4: outputs change only every 4th clk; frame length 4*800*525 clk; frame_start pulses once per frame.
- Reset mid-frame: assert reset at v=300 → outputs go immediately to hsync=1, vsync=1, rgb=0. After release, the first frame is blank-window BG until frame_start.
